// File: rtl/line_sum_sched_if.sv
// ---------------------------------------------------------------------------
// line_sum_sched_if
//   Bundles every handshake and bus signal of the 3-row column-sum sequencer:
//   the uart_rx byte input, both line-FIFO ports, the uart_tx send handshake
//   and the frame status outputs.
//
//   Handshake semantics (the only place they are written down):
//     rx_valid/rx_data : level from uart_rx; each rising edge of rx_valid is
//                        exactly one byte, and rx_data is stable while
//                        rx_valid is high.
//     fifoN_wr_en      : one-cycle write strobe, fifoN_din is valid with it.
//     fifoN_rd_en      : one-cycle read strobe, fifoN_dout is valid on the
//                        following cycle (non-FWFT, 1-cycle read latency).
//     tx_en/tx_busy    : tx_en is a one-cycle send pulse, asserted only when
//                        tx_busy was low on the previous cycle. tx_data holds
//                        its value until the next send.
//     frame_done       : one-cycle pulse when a frame's FIFO drain finishes.
//     ovf              : sticky until reset; a byte or a sum was dropped.
//
//   master : the sequencer (drives both FIFOs and the tx handshake)
//   slave  : the environment (uart_rx, FIFOs, uart_tx)
// ---------------------------------------------------------------------------
interface line_sum_sched_if;
   logic [7:0] rx_data;
   logic       rx_valid;

   logic       fifo1_wr_en;
   logic [7:0] fifo1_din;
   logic       fifo1_rd_en;
   logic [7:0] fifo1_dout;

   logic       fifo2_wr_en;
   logic [7:0] fifo2_din;
   logic       fifo2_rd_en;
   logic [7:0] fifo2_dout;

   logic [7:0] tx_data;
   logic       tx_en;
   logic       tx_busy;

   logic       frame_done;
   logic       ovf;

   modport master (
      input  rx_data, rx_valid,
      output fifo1_wr_en, fifo1_din, fifo1_rd_en,
      input  fifo1_dout,
      output fifo2_wr_en, fifo2_din, fifo2_rd_en,
      input  fifo2_dout,
      output tx_data, tx_en,
      input  tx_busy,
      output frame_done, ovf
   );

   modport slave (
      output rx_data, rx_valid,
      input  fifo1_wr_en, fifo1_din, fifo1_rd_en,
      output fifo1_dout,
      input  fifo2_wr_en, fifo2_din, fifo2_rd_en,
      output fifo2_dout,
      input  tx_data, tx_en,
      output tx_busy,
      input  frame_done, ovf
   );
endinterface

// File: rtl/line_sum_sched.sv
// ---------------------------------------------------------------------------
// line_sum_sched
//   Sequencer for the 3-row column-sum datapath. Bytes of a ROW x COL frame
//   arrive from uart_rx in row-major order. Two external line FIFOs act as
//   row-delay buffers: FIFO1 holds row r-2, FIFO2 holds row r-1. For every
//   byte of rows 2..ROW-1 the column sum of rows r-2, r-1 and r is sent to
//   uart_tx. After the last byte the FIFOs are drained so the next frame
//   starts with both of them empty.
//
//   Optional feature macro: SUM_SAT_EN
//     defined   : result saturates to 8'hFF when the 10-bit sum exceeds 255
//     undefined : result is the low 8 bits of the sum (wraps modulo 256)
//
//   state_dbg encoding: 0 FILL1, 1 FILL2, 2 SUM, 3 FLUSH.
// ---------------------------------------------------------------------------
module line_sum_sched #(
   parameter int ROW = 6,
   parameter int COL = 5
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   line_sum_sched_if.master bus,
   output logic [1:0]       state_dbg
);

   localparam int MAXD = (ROW > COL) ? ROW : COL;
   localparam int CW   = $clog2(MAXD) + 1;

`ifdef SUM_SAT_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      FILL1 = 2'd0,
      FILL2 = 2'd1,
      SUM   = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t        state;

   // rx_valid synchroniser and edge detector
   logic          rx_s1;
   logic          rx_s2;
   logic          rx_s3;
   logic          rx_edge;

   // accept / drop decision for the current edge
   logic          pipe_busy;
   logic          accept;
   logic          drop_byte;

   // frame position
   logic [CW-1:0] row_cnt;
   logic [CW-1:0] col_cnt;
   logic [CW-1:0] col_nxt;
   logic          row_wrap;

   // SUM pipeline: p1 = FIFO read issued, p2 = FIFO data valid,
   // p3 = folded sum ready for the pending register
   logic [7:0]    byte_q;
   logic          p1;
   logic          p2;
   logic          p3;
   logic [9:0]    sum_q;
   logic [7:0]    result;

   // one-deep output queue in front of uart_tx
   logic          pend_v;
   logic [7:0]    pend_d;
   logic          drop_sum;

   // Reduce the 10-bit column sum to the 8-bit value sent to uart_tx.
   function automatic logic [7:0] fold_sum(input logic [9:0] s);
      logic [7:0] r;
      if (SAT_EN && (s[9:8] != 2'b00))
         r = 8'hFF;
      else
         r = s[7:0];
      return r;
   endfunction

   assign rx_edge   = rx_s2 & ~rx_s3;
   assign pipe_busy = p1 | p2 | p3;
   assign state_dbg = state;
   assign result    = fold_sum(sum_q);
   assign drop_sum  = p3 && pend_v && bus.tx_busy;

   // An edge is taken in the fill rows unconditionally, in the sum rows only
   // when the previous byte has left the pipeline, and never while flushing.
   always_comb begin
      accept = 1'b0;
      case (state)
         FILL1:   accept = rx_edge;
         FILL2:   accept = rx_edge;
         SUM:     accept = rx_edge && !pipe_busy;
         default: accept = 1'b0;
      endcase
      drop_byte = rx_edge && !accept;
   end

   // Next column index and end-of-row flag for an accepted byte.
   always_comb begin
      row_wrap = (col_cnt == CW'(COL - 1));
      col_nxt  = row_wrap ? '0 : col_cnt + CW'(1);
   end

   // Two-flop synchroniser on rx_valid plus a third flop for edge detection.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1 <= 1'b0;
         rx_s2 <= 1'b0;
         rx_s3 <= 1'b0;
      end else begin
         rx_s1 <= bus.rx_valid;
         rx_s2 <= rx_s1;
         rx_s3 <= rx_s2;
      end
   end

   // Main sequencer: frame position, FIFO strobes, drain and frame_done.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= FILL1;
         row_cnt         <= '0;
         col_cnt         <= '0;
         byte_q          <= 8'd0;
         p1              <= 1'b0;
         bus.fifo1_wr_en <= 1'b0;
         bus.fifo1_din   <= 8'd0;
         bus.fifo1_rd_en <= 1'b0;
         bus.fifo2_wr_en <= 1'b0;
         bus.fifo2_din   <= 8'd0;
         bus.fifo2_rd_en <= 1'b0;
         bus.frame_done  <= 1'b0;
      end else begin
         bus.fifo1_wr_en <= 1'b0;
         bus.fifo2_wr_en <= 1'b0;
         bus.fifo1_rd_en <= 1'b0;
         bus.fifo2_rd_en <= 1'b0;
         bus.frame_done  <= 1'b0;
         p1              <= 1'b0;

         // Row shift: r-1 moves down into FIFO1, the current byte into FIFO2.
         if (p2) begin
            bus.fifo1_wr_en <= 1'b1;
            bus.fifo1_din   <= bus.fifo2_dout;
            bus.fifo2_wr_en <= 1'b1;
            bus.fifo2_din   <= byte_q;
         end

         case (state)
            FILL1: begin
               if (accept) begin
                  bus.fifo1_wr_en <= 1'b1;
                  bus.fifo1_din   <= bus.rx_data;
                  byte_q          <= bus.rx_data;
                  col_cnt         <= col_nxt;
                  if (row_wrap) begin
                     row_cnt <= row_cnt + CW'(1);
                     state   <= FILL2;
                  end
               end
            end

            FILL2: begin
               if (accept) begin
                  bus.fifo2_wr_en <= 1'b1;
                  bus.fifo2_din   <= bus.rx_data;
                  byte_q          <= bus.rx_data;
                  col_cnt         <= col_nxt;
                  if (row_wrap) begin
                     row_cnt <= row_cnt + CW'(1);
                     state   <= SUM;
                  end
               end
            end

            SUM: begin
               if (accept) begin
                  bus.fifo1_rd_en <= 1'b1;
                  bus.fifo2_rd_en <= 1'b1;
                  byte_q          <= bus.rx_data;
                  p1              <= 1'b1;
                  col_cnt         <= col_nxt;
                  if (row_wrap) begin
                     if (row_cnt == CW'(ROW - 1)) begin
                        row_cnt <= '0;
                        state   <= FLUSH;
                     end else begin
                        row_cnt <= row_cnt + CW'(1);
                     end
                  end
               end
            end

            FLUSH: begin
               // Wait for the last row shift to land, then read COL entries
               // from both FIFOs; col_cnt counts the reads issued.
               if (!pipe_busy) begin
                  if (col_cnt == CW'(COL)) begin
                     col_cnt        <= '0;
                     bus.frame_done <= 1'b1;
                     state          <= FILL1;
                  end else begin
                     bus.fifo1_rd_en <= 1'b1;
                     bus.fifo2_rd_en <= 1'b1;
                     col_cnt         <= col_cnt + CW'(1);
                  end
               end
            end

            default: state <= FILL1;
         endcase
      end
   end

   // Sum pipeline: add the two delayed rows to the current byte when the
   // FIFO data is valid, then hand the folded result to the output queue.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         p2    <= 1'b0;
         p3    <= 1'b0;
         sum_q <= 10'd0;
      end else begin
         p2 <= p1;
         p3 <= p2;
         if (p2) begin
            sum_q <= {2'b00, bus.fifo1_dout} + {2'b00, bus.fifo2_dout}
                   + {2'b00, byte_q};
         end
      end
   end

   // Output queue: send the pending sum when uart_tx is idle; a sum arriving
   // while the queue is still blocked is dropped and flagged.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_v      <= 1'b0;
         pend_d      <= 8'd0;
         bus.tx_en   <= 1'b0;
         bus.tx_data <= 8'd0;
         bus.ovf     <= 1'b0;
      end else begin
         bus.tx_en <= 1'b0;
         if (pend_v && !bus.tx_busy) begin
            bus.tx_en   <= 1'b1;
            bus.tx_data <= pend_d;
            pend_v      <= 1'b0;
         end
         // A result landing on the cycle the queue empties is kept.
         if (p3 && !drop_sum) begin
            pend_v <= 1'b1;
            pend_d <= result;
         end
         if (drop_sum || drop_byte) begin
            bus.ovf <= 1'b1;
         end
      end
   end

endmodule
